// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of a five-stage MIPS pipeline.
// Owns the program counter and drives the instruction SRAM request port.
// A one-entry redirect buffer captures a branch resolved while IF is stalled
// so it is applied on the first unstalled edge.
// Optional feature macro: FETCH_ADEL_EN (misaligned-fetch flag and SRAM
// request suppression). Default build leaves it out.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [32:0]        br_bus,
  output logic [32:0]        if_to_id_bus,
  output logic               inst_sram_en,
  output logic [3:0]         inst_sram_wen,
  output logic [31:0]        inst_sram_addr,
  output logic [31:0]        inst_sram_wdata
`ifdef FETCH_ADEL_EN
  ,
  output logic               fetch_adel
`endif
);

  typedef enum logic {
    RB_EMPTY = 1'b0,
    RB_FULL  = 1'b1
  } rb_state_e;

  logic        br_e;
  logic [31:0] br_addr;
  logic        if_stop;
  logic [31:0] next_pc;

  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  rb_state_e   rb_state_q, rb_state_d;
  logic [31:0] rb_addr_q, rb_addr_d;

  // Only bit 0 of the stall vector concerns IF; the rest belong to later stages.
  logic stall_unused;
  assign stall_unused = ^stall;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign if_stop = stall[0];

  // Next-PC select: live redirect beats buffered redirect beats sequential.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (br_e) begin
      next_pc = br_addr;
    end else if (rb_state_q == RB_FULL) begin
      next_pc = rb_addr_q;
    end
  end

  // Next-state logic for PC, fetch enable and the redirect buffer FSM.
  always_comb begin
    pc_d       = pc_q;
    ce_d       = ce_q;
    rb_state_d = rb_state_q;
    rb_addr_d  = rb_addr_q;
    if (!if_stop) begin
      // Any buffered redirect is consumed (or overridden) by this advance.
      pc_d       = next_pc;
      ce_d       = 1'b1;
      rb_state_d = RB_EMPTY;
    end else begin
      case (rb_state_q)
        RB_EMPTY: begin
          if (br_e) begin
            rb_state_d = RB_FULL;
            rb_addr_d  = br_addr;
          end
        end
        RB_FULL: begin
          // A newer redirect replaces the older one still waiting.
          if (br_e) begin
            rb_addr_d = br_addr;
          end
        end
        default: rb_state_d = RB_EMPTY;
      endcase
    end
  end

  // State registers; reset parks PC one word before the boot vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC - 32'd4;
      ce_q       <= 1'b0;
      rb_state_q <= RB_EMPTY;
      rb_addr_q  <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      ce_q       <= ce_d;
      rb_state_q <= rb_state_d;
      rb_addr_q  <= rb_addr_d;
    end
  end

  assign if_to_id_bus    = {ce_q, pc_q};
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;

`ifdef FETCH_ADEL_EN
  // A misaligned fetch is flagged downstream and never reaches the SRAM.
  assign fetch_adel   = ce_q & (pc_q[1:0] != 2'b00);
  assign inst_sram_en = ce_q & ~fetch_adel;
`else
  assign inst_sram_en = ce_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table plus hand-written
// reset-with-full-buffer sequence, checked through an expected-result queue.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = 6'd0;
  logic [32:0] br_bus = 33'd0;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
`ifdef FETCH_ADEL_EN
  logic        fetch_adel;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC(32'hBFC0_0000),
    .STALL_W (6)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .br_bus         (br_bus),
    .if_to_id_bus   (if_to_id_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata)
`ifdef FETCH_ADEL_EN
    ,
    .fetch_adel     (fetch_adel)
`endif
  );

  typedef struct {
    logic [5:0]  stall;
    logic        br_e;
    logic [31:0] br_addr;
    logic        ce;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic exp_en(input logic ce, input logic [31:0] pc);
`ifdef FETCH_ADEL_EN
    return ce && (pc[1:0] == 2'b00);
`else
    return ce;
`endif
  endfunction

  task automatic check_outputs(input string tag, input logic ce, input logic [31:0] pc);
    check($sformatf("%s bus", tag), if_to_id_bus, {ce, pc});
    check($sformatf("%s addr", tag), {1'b0, inst_sram_addr}, {1'b0, pc});
    check($sformatf("%s en", tag), {32'd0, inst_sram_en}, {32'd0, exp_en(ce, pc)});
    check($sformatf("%s wen", tag), {29'd0, inst_sram_wen}, 33'd0);
    check($sformatf("%s wdata", tag), {1'b0, inst_sram_wdata}, 33'd0);
`ifdef FETCH_ADEL_EN
    check($sformatf("%s adel", tag), {32'd0, fetch_adel},
          {32'd0, ce && (pc[1:0] != 2'b00)});
`endif
  endtask

  // Called shortly after a rising edge: drive inputs, queue the expectation,
  // let one edge pass, then pop and compare.
  task automatic step(input logic [5:0] s, input logic b, input logic [31:0] a,
                      input logic ce, input logic [31:0] pc, input int id);
    exp_t e;
    stall  = s;
    br_bus = {b, a};
    sb_q.push_back('{ce: ce, pc: pc, id: id});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      e = sb_q.pop_front();
      check_outputs($sformatf("v%0d", e.id), e.ce, e.pc);
    end
  endtask

  task automatic add(input logic [5:0] s, input logic b, input logic [31:0] a,
                     input logic [31:0] pc);
    vecs.push_back('{stall: s, br_e: b, br_addr: a, ce: 1'b1, pc: pc});
  endtask

  initial begin
    // Boot
    add(6'h00, 1'b0, 32'h0,         32'hBFC0_0000);
    add(6'h00, 1'b0, 32'h0,         32'hBFC0_0004);
    add(6'h00, 1'b0, 32'h0,         32'hBFC0_0008);
    add(6'h00, 1'b0, 32'h0,         32'hBFC0_000C);
    add(6'h00, 1'b0, 32'h0,         32'hBFC0_0010);
    // Redirect at BFC0_0010
    add(6'h00, 1'b1, 32'hBFC0_0100, 32'hBFC0_0100);
    add(6'h00, 1'b0, 32'h0,         32'hBFC0_0104);
    // Stall hold at BFC0_0020
    add(6'h00, 1'b1, 32'hBFC0_0020, 32'hBFC0_0020);
    add(6'h01, 1'b0, 32'h0,         32'hBFC0_0020);
    add(6'h01, 1'b0, 32'h0,         32'hBFC0_0020);
    add(6'h01, 1'b0, 32'h0,         32'hBFC0_0020);
    add(6'h01, 1'b0, 32'h0,         32'hBFC0_0020);
    add(6'h00, 1'b0, 32'h0,         32'hBFC0_0024);
    // Buffered redirect, newer overwrites older
    add(6'h01, 1'b1, 32'h8000_0040, 32'hBFC0_0024);
    add(6'h01, 1'b0, 32'h0,         32'hBFC0_0024);
    add(6'h01, 1'b1, 32'h8000_0080, 32'hBFC0_0024);
    add(6'h00, 1'b0, 32'h0,         32'h8000_0080);
    add(6'h00, 1'b0, 32'h0,         32'h8000_0084);
    // Live redirect beats buffered one
    add(6'h01, 1'b1, 32'h8000_0040, 32'h8000_0084);
    add(6'h01, 1'b0, 32'h0,         32'h8000_0084);
    add(6'h00, 1'b1, 32'h9000_0000, 32'h9000_0000);
    add(6'h00, 1'b0, 32'h0,         32'h9000_0004);
    // Buffer stays clear across a plain stall
    add(6'h01, 1'b0, 32'h0,         32'h9000_0004);
    add(6'h00, 1'b0, 32'h0,         32'h9000_0008);
    // Upper stall bits do not stop IF
    add(6'h3E, 1'b0, 32'h0,         32'h9000_000C);
    // Wrap
    add(6'h00, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    add(6'h00, 1'b0, 32'h0,         32'h0000_0000);
    add(6'h00, 1'b0, 32'h0,         32'h0000_0004);
    // Misaligned fetch
    add(6'h00, 1'b1, 32'hBFC0_0002, 32'hBFC0_0002);
    add(6'h00, 1'b0, 32'h0,         32'hBFC0_0006);
    add(6'h00, 1'b1, 32'hBFC0_0100, 32'hBFC0_0100);

    // Reset asserted away from a clock edge must act at once
    #2 rst = 1'b1;
    #1 check_outputs("reset_async", 1'b0, 32'hBFBF_FFFC);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_outputs($sformatf("reset_c%0d", i), 1'b0, 32'hBFBF_FFFC);
    end
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].stall, vecs[i].br_e, vecs[i].br_addr, vecs[i].ce, vecs[i].pc, i);
    end

    // Reset while stalled with a full buffer discards the buffered redirect
    step(6'h01, 1'b1, 32'hA000_0000, 1'b1, 32'hBFC0_0100, 100);
    step(6'h01, 1'b0, 32'h0,         1'b1, 32'hBFC0_0100, 101);
    #2 rst = 1'b1;
    #1 check_outputs("midstall_rst_async", 1'b0, 32'hBFBF_FFFC);
    @(posedge clk);
    #1 check_outputs("midstall_rst_held", 1'b0, 32'hBFBF_FFFC);
    rst = 1'b0;
    step(6'h00, 1'b0, 32'h0, 1'b1, 32'hBFC0_0000, 102);
    step(6'h00, 1'b0, 32'h0, 1'b1, 32'hBFC0_0004, 103);

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch (IF) stage of the five-stage MIPS pipeline. It owns the program counter and drives the instruction SRAM request port. It consumes the redirect bus `br_bus` produced by the decode stage and produces `if_to_id_bus` for the decode stage's pipeline register. A one-entry redirect buffer ensures that a branch resolved while IF is stalled is never lost.

## Interface
Parameters:
- `RESET_PC`, default 32'hBFC0_0000: address of the first fetched instruction.
- `STALL_W`, default 6: width of the stall vector (`StallBus`).

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `stall`  in  STALL_W  stall vector. Bit 0 = IF stop (1 = Stop, 0 = NoStop).
- `br_bus`  in  33  `{br_e, br_addr[31:0]}` from decode. `br_e` = take redirect.
- `if_to_id_bus`  out  33  `{ce, pc[31:0]}` to decode.
- `inst_sram_en`  out  1  SRAM read enable.
- `inst_sram_wen`  out  4  SRAM byte write enables, constant 4'b0.
- `inst_sram_addr`  out  32  SRAM address, equals `pc`.
- `inst_sram_wdata`  out  32  SRAM write data, constant 32'b0.
- `fetch_adel`  out  1  misaligned-fetch flag. Present only with `FETCH_ADEL_EN`.

## Operation
- State registers:
  - `pc`: 32 bits.
  - `ce`: 1 bit.
  - redirect buffer: `rb_valid` + `rb_addr` (32 bits).
- Next-PC priority, highest first:
  1. live `br_e` → `br_addr`
  2. `rb_valid` → `rb_addr`
  3. otherwise `pc + 4`, 32-bit, wrapping FFFF_FFFC → 0000_0000.
- Advance rule: when `stall[0]==0`, on the rising clock edge:
  - `pc <= next_pc`
  - `ce <= 1`
  - `rb_valid <= 0`
- Hold rule: when `stall[0]==1`, `pc` and `ce` hold. Buffer behaviour while held:
  - `br_e==1`: `rb_valid <= 1`, `rb_addr <= br_addr`. A newer redirect overwrites an older buffered one.
  - `br_e==0`: the buffer holds.
- Buffer state machine:
  - EMPTY (`rb_valid=0`) → FULL on a stalled `br_e`.
  - FULL → EMPTY on the first unstalled edge.
  - FULL → FULL on a further stalled `br_e`, which overwrites the address.
- `inst_sram_en = ce`. `inst_sram_addr = pc`. Write enables and write data are tied to zero.
- `if_to_id_bus = {ce, pc}`. Decode latches it; the SRAM returns the instruction one cycle after the request.
- Delay slot: a redirect seen in cycle N takes effect in `pc` at the edge ending cycle N. The instruction already requested in cycle N (the delay slot) is kept and is not squashed.

## Timing
- Reset (async, immediate):
  - `pc = RESET_PC - 4` (32'hBFBF_FFFC)
  - `ce = 0`, `rb_valid = 0`, `rb_addr = 0`
  - `inst_sram_en = 0`, `if_to_id_bus = {1'b0, 32'hBFBF_FFFC}`
  - `fetch_adel = 0`
- First unstalled edge after reset deassertion: `pc = RESET_PC`, `ce = 1`, `inst_sram_en = 1`.
- Steady state: one new fetch address per unstalled cycle, with zero cycles of redirect latency.
- Stall held for K cycles: address and enable are held stable for K cycles. The SRAM re-reads the same address, which is harmless.
- Stall and `br_e` in the same cycle: the redirect is buffered. The first unstalled edge loads `rb_addr`, unless a live `br_e` is present, which wins.
- Reset asserted mid-stall or with the buffer full: all state returns to reset values immediately, and the buffered redirect is discarded.

## Configuration
- `FETCH_ADEL_EN` defined:
  - `fetch_adel = ce & (pc[1:0] != 0)`.
  - While `fetch_adel` is 1, `inst_sram_en` is forced to 0.
  - `pc` advancement is unchanged; the exception stage handles the fault.
- `FETCH_ADEL_EN` not defined:
  - The `fetch_adel` port does not exist.
  - `inst_sram_en = ce` unconditionally, and misalignment is ignored.

## Test plan
- Reset/boot: assert `rst` for 3 cycles, release, no stall.
  - During reset: `inst_sram_en` = 0, `pc` = BFBF_FFFC.
  - Next three edges: addresses BFC0_0000, BFC0_0004, BFC0_0008, with `ce` = 1.
- Redirect: at `pc` = BFC0_0010, drive `br_e` = 1, `br_addr` = BFC0_0100 for one cycle.
  - Next address: BFC0_0100.
  - Address after that: BFC0_0104.
- Stall hold: assert `stall[0]` for 4 cycles at `pc` = BFC0_0020.
  - Address stays BFC0_0020 with `en` = 1.
  - After release: BFC0_0024.
- Buffered redirect: with `stall[0]` = 1, pulse `br_e` with `br_addr` = 8000_0040. Two cycles later, pulse `br_e` with 8000_0080. Release the stall with `br_e` = 0.
  - First unstalled address: 8000_0080.
  - `rb_valid` = 0 afterwards.
- Live-over-buffered: buffer holds 8000_0040. Release the stall with live `br_e` = 1, `br_addr` = 9000_0000.
  - Result: `pc` = 9000_0000, buffer cleared.
- Wrap and ADEL: force `pc` to FFFF_FFFC via a redirect and advance.
  - Next address: 0000_0000.
  - With `FETCH_ADEL_EN`: redirect to BFC0_0002 gives `fetch_adel` = 1 and `inst_sram_en` = 0.
